// File: rtl/tpu_instr_dispatch_if.sv
// Bundles the dispatcher's command, thread-memory and TPU instruction-port signals.
interface tpu_instr_dispatch_if #(
  parameter int unsigned WIDTH_INSTR = 32,
  parameter int unsigned WIDTH_ISSUE = 8,
  parameter int unsigned WIDTH_ADDR  = 10
);
  logic                   I_Start;
  logic [WIDTH_ADDR-1:0]  I_Base;
  logic [WIDTH_ADDR-1:0]  I_Length;
  logic [WIDTH_ISSUE-1:0] I_IssueNo;
  logic                   O_Ready;
  logic                   O_Mem_Re;
  logic [WIDTH_ADDR-1:0]  O_Mem_Addr;
  logic [WIDTH_INSTR-1:0] I_Mem_Data;
  logic                   I_En_Exe;
  logic                   O_Req;
  logic [WIDTH_ISSUE-1:0] O_IssueNo;
  logic [WIDTH_INSTR-1:0] O_Instr;
  logic                   I_Nack;
  logic                   I_Term;
  logic [WIDTH_ISSUE-1:0] I_Term_IssueNo;
  logic                   O_Done;
  logic                   O_Err;

  // Dispatcher side.
  modport master (
    input  I_Start, I_Base, I_Length, I_IssueNo, I_Mem_Data, I_En_Exe,
           I_Nack, I_Term, I_Term_IssueNo,
    output O_Ready, O_Mem_Re, O_Mem_Addr, O_Req, O_IssueNo, O_Instr,
           O_Done, O_Err
  );

  // MPU control, thread memory and TPU side.
  modport slave (
    output I_Start, I_Base, I_Length, I_IssueNo, I_Mem_Data, I_En_Exe,
           I_Nack, I_Term, I_Term_IssueNo,
    input  O_Ready, O_Mem_Re, O_Mem_Addr, O_Req, O_IssueNo, O_Instr,
           O_Done, O_Err
  );
endinterface

// File: rtl/tpu_instr_dispatch.sv
// Streams a thread's instructions from MPU thread memory to one TPU, honouring
// Nack/enable back-pressure, then waits for the matching termination report.
module tpu_instr_dispatch #(
  parameter int unsigned WIDTH_INSTR = 32,
  parameter int unsigned WIDTH_ISSUE = 8,
  parameter int unsigned WIDTH_ADDR  = 10,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  tpu_instr_dispatch_if.master  bus
);

  localparam int unsigned WIDTH_WAIT = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WIDTH_WAIT-1:0] WAIT_LAST =
    (TIMEOUT == 0) ? '0 : WIDTH_WAIT'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TERM} state_e;

  state_e                 state, state_nxt;
  logic [WIDTH_ADDR-1:0]  base_q, len_q, sent_q;
  logic [WIDTH_ISSUE-1:0] issue_q;
  logic [WIDTH_INSTR-1:0] hold_q;
  logic                   rd_vld_q, hold_vld_q, done_q, err_q;
  logic [WIDTH_WAIT-1:0]  wait_q;

  logic                   pend_c, req_c, accept_c, start_c, timeout_c;
  logic                   mem_re_c, done_nxt, err_nxt;
  logic [WIDTH_ADDR-1:0]  mem_addr_c;
  logic [WIDTH_INSTR-1:0] instr_c;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, memory fetch and beat handshake.
  always_comb begin
    state_nxt  = state;
    mem_re_c   = 1'b0;
    mem_addr_c = '0;
    req_c      = 1'b0;
    accept_c   = 1'b0;
    start_c    = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    pend_c     = rd_vld_q | hold_vld_q;
    // Fresh read data goes straight out; otherwise replay the held word.
    instr_c    = rd_vld_q ? bus.I_Mem_Data : hold_q;
    timeout_c  = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
    case (state)
      IDLE: begin
        if (bus.I_Start) begin
          if (bus.I_Length == '0) begin
            err_nxt = 1'b1;
          end else begin
            start_c    = 1'b1;
            mem_re_c   = 1'b1;
            mem_addr_c = bus.I_Base;
            state_nxt  = SEND;
          end
        end
      end
      SEND: begin
        req_c    = pend_c & bus.I_En_Exe;
        accept_c = req_c & ~bus.I_Nack;
        if (accept_c) begin
          if (sent_q + WIDTH_ADDR'(1) == len_q) begin
            state_nxt = WAIT_TERM;
          end else begin
            mem_re_c   = 1'b1;
            mem_addr_c = base_q + sent_q + WIDTH_ADDR'(1);
          end
        end
      end
      WAIT_TERM: begin
        if (bus.I_Term && (bus.I_Term_IssueNo == issue_q)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          if (bus.I_Term) err_nxt = 1'b1;
          if (timeout_c) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Thread context, skid register and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q     <= '0;
      len_q      <= '0;
      sent_q     <= '0;
      issue_q    <= '0;
      hold_q     <= '0;
      rd_vld_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      rd_vld_q <= mem_re_c;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      if (start_c) begin
        base_q  <= bus.I_Base;
        len_q   <= bus.I_Length;
        issue_q <= bus.I_IssueNo;
        sent_q  <= '0;
      end else if (accept_c) begin
        sent_q <= sent_q + WIDTH_ADDR'(1);
      end
      if (rd_vld_q) hold_q <= bus.I_Mem_Data;
      hold_vld_q <= (state == SEND) ? (pend_c & ~accept_c) : 1'b0;
      wait_q     <= (state == WAIT_TERM) ? wait_q + WIDTH_WAIT'(1) : '0;
    end
  end

  assign bus.O_Ready    = (state == IDLE);
  assign bus.O_Mem_Re   = mem_re_c;
  assign bus.O_Mem_Addr = mem_addr_c;
  assign bus.O_Req      = req_c;
  assign bus.O_IssueNo  = issue_q;
  assign bus.O_Instr    = instr_c;
  assign bus.O_Done     = done_q;
  assign bus.O_Err      = err_q;

endmodule

// File: tb/tb_tpu_instr_dispatch.sv
// Directed bench for tpu_instr_dispatch: per-cycle vector tables plus
// hand-written timeout and mid-dispatch reset sequences.
module tb_tpu_instr_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tpu_instr_dispatch_if #(.WIDTH_INSTR(32), .WIDTH_ISSUE(8), .WIDTH_ADDR(10)) bus ();

  tpu_instr_dispatch #(
    .WIDTH_INSTR(32), .WIDTH_ISSUE(8), .WIDTH_ADDR(10), .TIMEOUT(16)
  ) u_dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.master)
  );

  function automatic logic [31:0] mw(input logic [9:0] a);
    return 32'hC0DE_0000 | 32'(a) | (32'(a) << 20);
  endfunction

  // Thread memory with one-cycle read latency.
  logic [31:0] mem_data = '0;
  always @(posedge clk) if (bus.O_Mem_Re) mem_data <= mw(bus.O_Mem_Addr);
  assign bus.I_Mem_Data = mem_data;

  typedef struct {
    string       tag;
    logic        start;
    logic [9:0]  base, len;
    logic [7:0]  iss;
    logic        en, nack, term;
    logic [7:0]  tiss;
    logic        e_ready, e_re;
    logic [9:0]  e_addr;
    logic        e_req;
    logic [31:0] e_instr;
    logic [7:0]  e_issue;
    logic        e_done, e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string tag, input logic st, input logic [9:0] bs,
      input logic [9:0] ln, input logic [7:0] is, input logic en, input logic nk,
      input logic tm, input logic [7:0] ti, input logic rdy, input logic re,
      input logic [9:0] ad, input logic rq, input logic [31:0] ins, input logic [7:0] eis,
      input logic dn, input logic er);
    vec_t v;
    v.tag = tag; v.start = st; v.base = bs; v.len = ln; v.iss = is;
    v.en = en; v.nack = nk; v.term = tm; v.tiss = ti;
    v.e_ready = rdy; v.e_re = re; v.e_addr = ad; v.e_req = rq; v.e_instr = ins;
    v.e_issue = eis; v.e_done = dn; v.e_err = er;
    return v;
  endfunction

  function automatic vec_t start_v(input string tag, input logic [9:0] bs, input logic [9:0] ln,
      input logic [7:0] is, input logic [7:0] eis, input logic re);
    return mk(tag, 1, bs, ln, is, 1, 0, 0, 0, 1, re, bs, 0, 0, eis, 0, 0);
  endfunction

  function automatic vec_t beat_v(input string tag, input logic en, input logic nk,
      input logic rq, input logic [31:0] ins, input logic re, input logic [9:0] ad,
      input logic [7:0] eis);
    return mk(tag, 0, 0, 0, 0, en, nk, 0, 0, 0, re, ad, rq, ins, eis, 0, 0);
  endfunction

  function automatic vec_t wait_v(input string tag, input logic tm, input logic [7:0] ti,
      input logic [7:0] eis, input logic er);
    return mk(tag, 0, 0, 0, 0, 1, 0, tm, ti, 0, 0, 0, 0, 0, eis, 0, er);
  endfunction

  function automatic vec_t idle_v(input string tag, input logic tm, input logic [7:0] ti,
      input logic [7:0] eis, input logic dn, input logic er);
    return mk(tag, 0, 0, 0, 0, 1, 0, tm, ti, 1, 0, 0, 0, 0, eis, dn, er);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [9:0] bs, input logic [9:0] ln,
      input logic [7:0] is, input logic en, input logic nk, input logic tm, input logic [7:0] ti);
    bus.I_Start = st; bus.I_Base = bs; bus.I_Length = ln; bus.I_IssueNo = is;
    bus.I_En_Exe = en; bus.I_Nack = nk; bus.I_Term = tm; bus.I_Term_IssueNo = ti;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ready"}, 32'(bus.O_Ready), 32'd1);
    chk({tag, " mem_re"}, 32'(bus.O_Mem_Re), 32'd0);
    chk({tag, " mem_addr"}, 32'(bus.O_Mem_Addr), 32'd0);
    chk({tag, " req"}, 32'(bus.O_Req), 32'd0);
    chk({tag, " issue"}, 32'(bus.O_IssueNo), 32'd0);
    chk({tag, " instr"}, bus.O_Instr, 32'd0);
    chk({tag, " done"}, 32'(bus.O_Done), 32'd0);
    chk({tag, " err"}, 32'(bus.O_Err), 32'd0);
  endtask

  task automatic run_vecs();
    foreach (vq[i]) begin
      vec_t v;
      string n;
      v = vq[i];
      n = $sformatf("%s[%0d]", v.tag, i);
      @(negedge clk);
      drive(v.start, v.base, v.len, v.iss, v.en, v.nack, v.term, v.tiss);
      #1;
      chk({n, " ready"}, 32'(bus.O_Ready), 32'(v.e_ready));
      chk({n, " mem_re"}, 32'(bus.O_Mem_Re), 32'(v.e_re));
      if (v.e_re) chk({n, " mem_addr"}, 32'(bus.O_Mem_Addr), 32'(v.e_addr));
      chk({n, " req"}, 32'(bus.O_Req), 32'(v.e_req));
      if (v.e_req) chk({n, " instr"}, bus.O_Instr, v.e_instr);
      chk({n, " issue"}, 32'(bus.O_IssueNo), 32'(v.e_issue));
      chk({n, " done"}, 32'(bus.O_Done), 32'(v.e_done));
      chk({n, " err"}, 32'(bus.O_Err), 32'(v.e_err));
    end
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Plain four-beat thread; a start during SEND must be ignored.
    vq.push_back(start_v("basic", 10'h010, 4, 8'h05, 8'h00, 1));
    vq.push_back(beat_v("basic", 1, 0, 1, mw(10'h010), 1, 10'h011, 8'h05));
    vq.push_back(mk("basic", 1, 10'h100, 2, 8'h09, 1, 0, 0, 0, 0, 1, 10'h012, 1, mw(10'h011), 8'h05, 0, 0));
    vq.push_back(beat_v("basic", 1, 0, 1, mw(10'h012), 1, 10'h013, 8'h05));
    vq.push_back(beat_v("basic", 1, 0, 1, mw(10'h013), 0, 10'h000, 8'h05));
    repeat (3) vq.push_back(wait_v("basic", 0, 0, 8'h05, 0));
    vq.push_back(wait_v("basic", 1, 8'h05, 8'h05, 0));
    vq.push_back(idle_v("basic", 0, 0, 8'h05, 1, 0));
    vq.push_back(idle_v("basic", 0, 0, 8'h05, 0, 0));
    run_vecs();

    // Nack on cycles 2-3 holds beat 1; a Term during SEND is ignored.
    vq.push_back(start_v("nack", 10'h010, 4, 8'h05, 8'h05, 1));
    vq.push_back(beat_v("nack", 1, 0, 1, mw(10'h010), 1, 10'h011, 8'h05));
    vq.push_back(beat_v("nack", 1, 1, 1, mw(10'h011), 0, 10'h000, 8'h05));
    vq.push_back(mk("nack", 0, 0, 0, 0, 1, 1, 1, 8'h05, 0, 0, 0, 1, mw(10'h011), 8'h05, 0, 0));
    vq.push_back(beat_v("nack", 1, 0, 1, mw(10'h011), 1, 10'h012, 8'h05));
    vq.push_back(beat_v("nack", 1, 0, 1, mw(10'h012), 1, 10'h013, 8'h05));
    vq.push_back(beat_v("nack", 1, 0, 1, mw(10'h013), 0, 10'h000, 8'h05));
    vq.push_back(wait_v("nack", 1, 8'h05, 8'h05, 0));
    vq.push_back(idle_v("nack", 0, 0, 8'h05, 1, 0));
    run_vecs();

    // Execution disabled on cycles 2-4.
    vq.push_back(start_v("en", 10'h010, 4, 8'h05, 8'h05, 1));
    vq.push_back(beat_v("en", 1, 0, 1, mw(10'h010), 1, 10'h011, 8'h05));
    repeat (3) vq.push_back(beat_v("en", 0, 0, 0, 0, 0, 10'h000, 8'h05));
    vq.push_back(beat_v("en", 1, 0, 1, mw(10'h011), 1, 10'h012, 8'h05));
    vq.push_back(beat_v("en", 1, 0, 1, mw(10'h012), 1, 10'h013, 8'h05));
    vq.push_back(beat_v("en", 1, 0, 1, mw(10'h013), 0, 10'h000, 8'h05));
    vq.push_back(wait_v("en", 1, 8'h05, 8'h05, 0));
    vq.push_back(idle_v("en", 0, 0, 8'h05, 1, 0));
    run_vecs();

    // Address wrap at the top of thread memory.
    vq.push_back(start_v("wrap", 10'h3FE, 3, 8'h07, 8'h05, 1));
    vq.push_back(beat_v("wrap", 1, 0, 1, mw(10'h3FE), 1, 10'h3FF, 8'h07));
    vq.push_back(beat_v("wrap", 1, 0, 1, mw(10'h3FF), 1, 10'h000, 8'h07));
    vq.push_back(beat_v("wrap", 1, 0, 1, mw(10'h000), 0, 10'h000, 8'h07));
    vq.push_back(wait_v("wrap", 1, 8'h07, 8'h07, 0));
    vq.push_back(idle_v("wrap", 0, 0, 8'h07, 1, 0));
    run_vecs();

    // Wrong issue number, then the right one; Term in IDLE is ignored.
    vq.push_back(start_v("mism", 10'h020, 1, 8'h05, 8'h07, 1));
    vq.push_back(beat_v("mism", 1, 0, 1, mw(10'h020), 0, 10'h000, 8'h05));
    vq.push_back(wait_v("mism", 1, 8'h06, 8'h05, 0));
    vq.push_back(wait_v("mism", 0, 0, 8'h05, 1));
    vq.push_back(wait_v("mism", 1, 8'h05, 8'h05, 0));
    vq.push_back(idle_v("mism", 1, 8'h05, 8'h05, 1, 0));
    vq.push_back(idle_v("mism", 0, 0, 8'h05, 0, 0));
    vq.push_back(idle_v("mism", 0, 0, 8'h05, 0, 0));
    run_vecs();

    // Zero-length start.
    vq.push_back(start_v("zero", 10'h050, 0, 8'h03, 8'h05, 0));
    vq.push_back(idle_v("zero", 0, 0, 8'h05, 0, 1));
    vq.push_back(idle_v("zero", 0, 0, 8'h05, 0, 0));
    run_vecs();

    // Timeout: WAIT_TERM entered at cycle 2, error expected at cycle 18.
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 10'h030, 1, 8'h0A, 1, 0, 0, 0);
      else        drive(0, 0, 0, 0, 1, 0, 0, 0);
      #1;
      if (c == 1) begin
        chk("tmo req", 32'(bus.O_Req), 32'd1);
        chk("tmo instr", bus.O_Instr, mw(10'h030));
      end
      if (c >= 2) begin
        chk($sformatf("tmo[%0d] err", c), 32'(bus.O_Err), 32'(c == 18));
        chk($sformatf("tmo[%0d] done", c), 32'(bus.O_Done), 32'd0);
        chk($sformatf("tmo[%0d] ready", c), 32'(bus.O_Ready), 32'(c >= 18));
      end
    end

    // Reset asserted in the middle of SEND.
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      rst = (c == 2);
      if (c == 0)      drive(1, 10'h010, 4, 8'h0B, 1, 0, 0, 0);
      else if (c == 4) drive(0, 0, 0, 0, 1, 0, 1, 8'h0B);
      else             drive(0, 0, 0, 0, 1, 0, 0, 0);
      #1;
      if (c == 2) begin
        chk("rst mid req", 32'(bus.O_Req), 32'd1);
        chk("rst mid instr", bus.O_Instr, mw(10'h011));
      end
      if (c == 3) check_reset_state("rst after");
      if (c == 5) begin
        chk("rst no done", 32'(bus.O_Done), 32'd0);
        chk("rst no err", 32'(bus.O_Err), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_instr_dispatch.md
Name: tpu_instr_dispatch

Overview:
MPU-side transmitter that feeds one TPU's instruction port. On a start command it reads a thread's instruction sequence from MPU thread memory and streams it to the TPU as request beats tagged with the thread's issue number. It honours the TPU's Nack back-pressure. It then waits for the TPU's termination report and checks that the returned issue number matches before releasing the thread slot.

Parameters:
WIDTH_INSTR, 32, width of one instruction word (instr_t)
WIDTH_ISSUE, 8, width of issue number (mpu_issue_no_t)
WIDTH_ADDR, 10, thread-memory address width; also the width of the length field
TIMEOUT, 4096, cycles allowed in WAIT_TERM before an error is flagged; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
I_Start  in  1  start dispatch; sampled only in IDLE
I_Base  in  WIDTH_ADDR  thread-memory start address
I_Length  in  WIDTH_ADDR  number of instructions to send
I_IssueNo  in  WIDTH_ISSUE  issue number of this thread
O_Ready  out  1  block is in IDLE and can accept I_Start
O_Mem_Re  out  1  thread-memory read enable
O_Mem_Addr  out  WIDTH_ADDR  thread-memory read address
I_Mem_Data  in  WIDTH_INSTR  read data, valid exactly 1 cycle after O_Mem_Re
I_En_Exe  in  1  TPU execution enable; when low, no beats are issued
O_Req  out  1  instruction beat valid toward the TPU
O_IssueNo  out  WIDTH_ISSUE  issue number, held for the whole thread
O_Instr  out  WIDTH_INSTR  instruction beat
I_Nack  in  1  TPU refuses the current beat (buffer full)
I_Term  in  1  TPU reports thread termination
I_Term_IssueNo  in  WIDTH_ISSUE  issue number returned with I_Term
O_Done  out  1  one-cycle pulse: thread terminated with a matching issue number
O_Err  out  1  one-cycle pulse: zero length, issue-number mismatch, or timeout

Behaviour:
- Reset: state goes to IDLE. O_Ready=1. O_Mem_Re=0, O_Req=0, O_Done=0, O_Err=0. O_Mem_Addr, O_IssueNo and O_Instr are all 0. All counters clear. Reset mid-dispatch abandons the thread and issues no O_Done.
- States: IDLE, SEND, WAIT_TERM.
- IDLE, I_Start=1, I_Length=0: O_Err pulses in the next cycle; state stays IDLE.
- IDLE, I_Start=1, I_Length!=0, start at cycle t:
  - Latch I_Base, I_Length and I_IssueNo. O_IssueNo takes the latched value.
  - O_Mem_Re=1 and O_Mem_Addr=I_Base combinationally in cycle t.
  - Enter SEND at t+1. O_Ready=0 from t+1 onward.
- Beat acceptance: a beat is accepted in a cycle when O_Req=1 and I_Nack=0.
- SEND, beat issue:
  - O_Req=1 whenever a fetched instruction is pending and I_En_Exe=1.
  - First beat is presented at t+1.
  - With no Nack, beats follow one per cycle: beat k is at t+1+k.
- Nack or I_En_Exe=0:
  - O_Instr and O_IssueNo hold their values.
  - No new memory read is issued.
  - The already-returned read data is kept in a skid/hold register; no instruction is dropped or duplicated.
  - When I_En_Exe=0, O_Req=0.
- Prefetch: in the cycle beat k is accepted and more beats remain, O_Mem_Re=1 and O_Mem_Addr=base+k+1.
- Address arithmetic wraps modulo 2^WIDTH_ADDR.
- End of SEND: when the last beat (count = length) is accepted, the next state is WAIT_TERM and O_Req=0.
- WAIT_TERM:
  - I_Term=1 with I_Term_IssueNo==O_IssueNo: O_Done pulses in the next cycle and state goes to IDLE.
  - I_Term=1 with any other issue number: O_Err pulses and the block stays in WAIT_TERM.
  - TIMEOUT!=0: the wait counter starts at 0 on entry and increments each cycle. Reaching TIMEOUT pulses O_Err and returns to IDLE.
- I_Term in IDLE or SEND is ignored.
- I_Start outside IDLE is ignored.
- O_Done and O_Err are never both 1 in the same cycle.

Test Plan:
- Base=0x010, Length=4, IssueNo=0x05, no Nack, I_En_Exe=1, start at cycle 0 -> O_Req=1 on cycles 1-4 with O_Instr=mem[0x010..0x013] in order and O_IssueNo=0x05. Then I_Term with 0x05 at cycle 8 -> O_Done=1 at cycle 9, O_Ready=1.
- Same thread, I_Nack=1 on cycles 2-3 -> beat 1 (mem[0x011]) is held stable on cycles 2-4. All 4 beats are sent exactly once; the last beat is at cycle 6.
- I_En_Exe=0 on cycles 2-4 -> O_Req=0 on those cycles and resumes at cycle 5 with the next unsent word; the sequence is unchanged.
- Base=0x3FE, Length=3 (WIDTH_ADDR=10) -> reads 0x3FE, 0x3FF, 0x000 in that order.
- In WAIT_TERM, I_Term with issue number 0x06 -> O_Err pulse with no O_Done. A following I_Term with 0x05 -> O_Done.
- Start with Length=0 -> a single O_Err pulse and no O_Req. TIMEOUT=16 with no I_Term -> O_Err 16 cycles after entering WAIT_TERM, then IDLE. Reset asserted mid-SEND -> all outputs return to reset values on the next cycle.
